// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared control definitions for the RV front end.
// Contents: XLEN, base opcode constants, fetch FSM state encoding,
// and a word-alignment helper used when redirect targets are forced aligned.
package rv_ctrl_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] JAL    = 7'b1101111;

  // IDLE: no request, REQ: request outstanding,
  // DROP: outstanding request whose data is discarded, HALT: fetch stopped.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DROP = 2'b10,
    HALT = 2'b11
  } ifu_state_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: generic synchronous FIFO, used as the fetch instruction buffer.
// Latency: a pushed entry is visible on o_head_dat the cycle after the push.
// Backpressure: o_full/o_count report occupancy; a push while full is dropped
// unless a pop happens in the same cycle; i_flush empties the FIFO (wins over push/pop).
// Ports: clk, reset (sync, active-high), i_push/i_push_dat, i_pop, i_flush,
//        o_head_dat, o_full, o_empty, o_count.
module ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_dat,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_head_dat,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full     = (r_count == DEPTH_C);
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
    end
  end

  // Storage is not reset; the head is only meaningful while o_empty is low.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetch with a small decode buffer.
// Latency: an acked word is on instr/instr_valid the cycle after imem_ack; zero-wait memory sustains 1/cycle.
// Backpressure: no new request is issued unless a buffer entry is free; instr_ready pops the head.
// Ports: clk, reset (sync, active-high); imem_req/imem_addr/imem_ack/imem_rdata memory side;
//        instr_valid/instr_ready/instr/op/instr_pc decode side; redirect/redirect_pc; misalign_err.
// Config: define IFU_MISALIGN_CHECK_EN to halt on a misaligned redirect target
//         (default build forces the target word aligned and misalign_err stays 0).
module instr_fetch_unit
  import rv_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        misalign_err
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  ifu_state_t      r_state, w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [XLEN-1:0] r_target, w_target_nxt;
  logic [XLEN-1:0] w_tgt;
  logic            r_misalign, w_misalign_nxt;
  logic            w_bad;
  logic            w_push, w_pop, w_full, w_empty;
  logic [AW:0]     w_count;
  logic [2*XLEN-1:0] w_head;

`ifdef IFU_MISALIGN_CHECK_EN
  assign w_tgt = redirect_pc;
  assign w_bad = (redirect_pc[1:0] != 2'b00);
`else
  assign w_tgt = align_word(redirect_pc);
  assign w_bad = 1'b0;
`endif

  // Outputs are gated by reset so they hold their reset values for the whole reset window.
  assign imem_req     = !reset && ((r_state == REQ) || (r_state == DROP));
  assign imem_addr    = reset ? RESET_PC : r_fetch_pc;
  assign instr_valid  = !reset && !w_empty;
  assign instr        = instr_valid ? w_head[XLEN-1:0] : '0;
  assign instr_pc     = instr_valid ? w_head[2*XLEN-1:XLEN] : '0;
  assign op           = instr[6:0];
  assign misalign_err = !reset && r_misalign;
  assign w_pop        = instr_valid && instr_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_target_nxt   = r_target;
    w_misalign_nxt = r_misalign;
    w_push         = 1'b0;
    case (r_state)
      IDLE: begin
        if (redirect && w_bad) begin
          w_misalign_nxt = 1'b1;
          w_state_nxt    = HALT;
        end else if (redirect) begin
          w_fetch_pc_nxt = w_tgt;
          w_state_nxt    = REQ;
        end else if (!w_full) begin
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (redirect && w_bad) begin
          w_misalign_nxt = 1'b1;
          w_state_nxt    = HALT;
        end else if (redirect && imem_ack) begin
          // Acked word belongs to the old path: drop it, go straight to the target.
          w_fetch_pc_nxt = w_tgt;
        end else if (redirect) begin
          // Address must stay stable until the ack, so park the target.
          w_target_nxt = w_tgt;
          w_state_nxt  = DROP;
        end else if (imem_ack) begin
          w_push         = 1'b1;
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          // Keep requesting only if the entry for the next ack is guaranteed.
          w_state_nxt    = (w_pop || ((w_count + 1'b1) < DEPTH_C)) ? REQ : IDLE;
        end
      end
      DROP: begin
        if (redirect && w_bad) begin
          w_misalign_nxt = 1'b1;
          w_state_nxt    = HALT;
        end else if (imem_ack) begin
          w_fetch_pc_nxt = redirect ? w_tgt : r_target;
          w_state_nxt    = REQ;
        end else if (redirect) begin
          w_target_nxt = w_tgt;
        end
      end
      HALT: begin
        w_state_nxt = HALT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_target   <= RESET_PC;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_target   <= w_target_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  ifu_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_dat ({r_fetch_pc, imem_rdata}),
    .i_pop      (w_pop),
    .i_flush    (redirect),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: self-checking bench for instr_fetch_unit.
// A memory model answers requests; accepted words go to an expected-instruction
// queue and are compared against every decode handshake.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misalign_err;

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .op           (op),
    .instr_pc     (instr_pc),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] dat;
    logic [6:0]  op;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [6:0]  exp_op;
  } vec_t;

  exp_t q[$];
  vec_t tbl[8];
  int   n_cmp = 0;
  int   n_err = 0;
  int   mem_mode = 0;
  logic drop_pending = 1'b0;
  logic found;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_mode == 0) return 32'h0000_0513;
    if (mem_mode == 1 && a >= 32'h200 && a < 32'h220) return tbl[int'((a - 32'h200) >> 2)].rdata;
    return ~a;
  endfunction

  // One clock cycle: called #1 after a rising edge, drives inputs for this cycle,
  // scores the decode handshake and the memory ack, then advances one edge.
  task automatic cyc(input logic ack_en, input logic rdy, input logic redir, input logic [31:0] rpc);
    exp_t e;
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    imem_ack    = ack_en & imem_req;
    imem_rdata  = mem_word(imem_addr);
    #1;
    if (instr_valid && instr_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got instr %08h at pc %08h, expected none", instr, instr_pc);
      end else begin
        e = q.pop_front();
        chk("sb_pc", instr_pc, e.pc);
        chk("sb_instr", instr, e.dat);
        chk("sb_op", {25'd0, op}, {25'd0, e.op});
      end
    end
    if (redir) begin
      q.delete();
      drop_pending = imem_req && !imem_ack;
    end else if (imem_ack) begin
      if (drop_pending) begin
        drop_pending = 1'b0;
      end else begin
        e.pc  = imem_addr;
        e.dat = imem_rdata;
        e.op  = imem_rdata[6:0];
        if (mem_mode == 1 && imem_addr >= 32'h200 && imem_addr < 32'h220)
          e.op = tbl[int'((imem_addr - 32'h200) >> 2)].exp_op;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    q.delete();
    drop_pending = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_0000);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{32'h200, 32'h0050_0093, 7'b0010011};
    tbl[1] = '{32'h204, 32'h0020_81B3, 7'b0110011};
    tbl[2] = '{32'h208, 32'h0000_A103, 7'b0000011};
    tbl[3] = '{32'h20C, 32'h0020_A223, 7'b0100011};
    tbl[4] = '{32'h210, 32'hFE20_8EE3, 7'b1100011};
    tbl[5] = '{32'h214, 32'h0000_80E7, 7'b1100111};
    tbl[6] = '{32'h218, 32'h0080_00EF, 7'b1101111};
    tbl[7] = '{32'h21C, 32'h0000_0513, 7'b0010011};

    // Reset release and zero-wait streaming.
    do_reset();
    mem_mode = 0;
    chk("zw_req_c1", {31'd0, imem_req}, 32'd1);
    chk("zw_addr0", imem_addr, 32'h0);
    chk("zw_valid_c1", {31'd0, instr_valid}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("zw_addr4", imem_addr, 32'h4);
    chk("zw_valid_c2", {31'd0, instr_valid}, 32'd1);
    chk("zw_op_c2", {25'd0, op}, {25'd0, 7'b0010011});
    chk("zw_pc_c2", instr_pc, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("zw_addr8", imem_addr, 32'h8);
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("zw_drain", q.size(), 32'd0);

    // Opcode table after a redirect that coincides with an ack.
    do_reset();
    mem_mode = 1;
    cyc(1'b1, 1'b1, 1'b1, 32'h200);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].pc);
      cyc(1'b1, 1'b1, 1'b0, 32'h0);
    end
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("tbl_drain", q.size(), 32'd0);

    // Backpressure: buffer fills to depth, fetch stops, nothing lost on resume.
    do_reset();
    mem_mode = 2;
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) begin
      chk("bp_req_low", {31'd0, imem_req}, 32'd0);
      chk("bp_valid", {31'd0, instr_valid}, 32'd1);
      chk("bp_buffered", q.size(), 32'd2);
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
    end
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      if (imem_req) begin
        found = 1'b1;
        chk("bp_resume_addr", imem_addr, 32'h8);
      end
      cyc(1'b1, 1'b1, 1'b0, 32'h0);
    end
    chk("bp_resume_seen", {31'd0, found}, 32'd1);
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("bp_drain", q.size(), 32'd0);

    // Redirect while the request to 0x8 waits: address held, data dropped.
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("drop_addr8", imem_addr, 32'h8);
    cyc(1'b0, 1'b1, 1'b1, 32'h100);
    repeat (2) begin
      chk("drop_hold_req", {31'd0, imem_req}, 32'd1);
      chk("drop_hold_addr", imem_addr, 32'h8);
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
    end
    chk("drop_hold_addr_ack", imem_addr, 32'h8);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("drop_next_addr", imem_addr, 32'h100);
    chk("drop_no_valid", {31'd0, instr_valid}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("drop_first_pc", instr_pc, 32'h100);

    // Redirect coinciding with an ack: acked word discarded.
    cyc(1'b1, 1'b1, 1'b1, 32'h300);
    chk("coin_next_addr", imem_addr, 32'h300);
    chk("coin_no_valid", {31'd0, instr_valid}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("coin_first_pc", instr_pc, 32'h300);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);

    // Misaligned redirect target.
    cyc(1'b1, 1'b1, 1'b1, 32'h102);
`ifdef IFU_MISALIGN_CHECK_EN
    repeat (3) begin
      chk("mis_err", {31'd0, misalign_err}, 32'd1);
      chk("mis_req_low", {31'd0, imem_req}, 32'd0);
      chk("mis_no_valid", {31'd0, instr_valid}, 32'd0);
      cyc(1'b1, 1'b1, 1'b0, 32'h0);
    end
`else
    chk("mis_aligned_addr", imem_addr, 32'h100);
    chk("mis_err_zero", {31'd0, misalign_err}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("mis_first_pc", instr_pc, 32'h100);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
`endif
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("mid_drain", q.size(), 32'd0);

    // Fetch address wraps from the top of the address space to zero.
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_addr_zero", imem_addr, 32'h0000_0000);
    chk("wrap_pc_top", instr_pc, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_pc_zero", instr_pc, 32'h0000_0000);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("wrap_drain", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
